// File: rtl/uart_lite_pkg.sv
// uart_lite_pkg: shared defaults and sizing helpers for the uart_lite FIFOs.
//   DATA_BITS_DFLT : default character width
//   RX_DEPTH_DFLT  : default receive FIFO depth (power of two, >= 2)
//   ptr_w()        : pointer width for a FIFO of a given depth (address bits + wrap bit)
package uart_lite_pkg;

  localparam int unsigned DATA_BITS_DFLT = 8;
  localparam int unsigned RX_DEPTH_DFLT  = 16;

  // The extra MSB is the wrap bit that separates full from empty.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// fifo_ptr_ctrl: read/write pointers, full/empty and occupancy for a
// power-of-two FIFO whose writer cannot be held off.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   push_req_i    : writer has a word this cycle
//   pop_req_i     : reader accepts the head this cycle (ignored when empty)
//   wr_addr_o     : storage address for the next write
//   rd_addr_o     : storage address of the head
//   push_c        : write accepted this cycle (may use the slot freed by pop_c)
//   pop_c         : head consumed this cycle
//   drop_c        : write refused because the FIFO is full and not popping
//   empty_c       : no stored words
//   full_c        : DEPTH stored words
//   count_o       : registered occupancy, 0..DEPTH
module fifo_ptr_ctrl
  import uart_lite_pkg::*;
#(
  parameter int unsigned DEPTH = RX_DEPTH_DFLT
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_req_i,
  input  logic                       pop_req_i,
  output logic [$clog2(DEPTH)-1:0]   wr_addr_o,
  output logic [$clog2(DEPTH)-1:0]   rd_addr_o,
  output logic                       push_c,
  output logic                       pop_c,
  output logic                       drop_c,
  output logic                       empty_c,
  output logic                       full_c,
  output logic [ptr_w(DEPTH)-1:0]    count_o
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);
  localparam int unsigned AW    = PTR_W - 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] count_q,  count_d;

  // Status, handshake qualification and next-state pointers/count.
  always_comb begin
    empty_c  = (wr_ptr_q == rd_ptr_q);
    full_c   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    pop_c    = pop_req_i && !empty_c;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    push_c   = push_req_i && (!full_c || pop_c);
    drop_c   = push_req_i && full_c && !pop_c;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + PTR_W'(1);
      2'b01:   count_d = count_q - PTR_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_addr_o = wr_ptr_q[AW-1:0];
  assign rd_addr_o = rd_ptr_q[AW-1:0];
  assign count_o   = count_q;

endmodule

// File: rtl/rx_char_fifo.sv
// rx_char_fifo: first-word-fall-through buffer between character recovery
// and the host side, with occupancy and a sticky overrun flag.
// Build option: define UART_LITE_RX_OVERRUN_EN to implement overrun_o;
// otherwise overrun_o is 0 and overrun_clr_i is ignored (drops still occur).
//   clk_i, rst_i   : oversampling clock, synchronous active-high reset
//   char_i/valid_i : recovered character and its one-cycle strobe (no backpressure)
//   char_o/valid_o : head character (combinational read) and non-empty
//   ready_i        : consumer accepts head when valid_o is high
//   count_o        : stored characters, 0..DEPTH
//   overrun_o      : sticky, a character was dropped while full
//   overrun_clr_i  : clears overrun_o (a coincident drop wins)
module rx_char_fifo
  import uart_lite_pkg::*;
#(
  parameter int unsigned DATA_BITS = DATA_BITS_DFLT,
  parameter int unsigned DEPTH     = RX_DEPTH_DFLT
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [DATA_BITS-1:0]     char_i,
  input  logic                     valid_i,
  output logic [DATA_BITS-1:0]     char_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [ptr_w(DEPTH)-1:0]  count_o,
  output logic                     overrun_o,
  input  logic                     overrun_clr_i
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0]        wr_addr, rd_addr;
  logic                 push_c, pop_c, drop_c, empty_c, full_c;
  logic [DATA_BITS-1:0] mem_q [DEPTH];

  fifo_ptr_ctrl #(
    .DEPTH (DEPTH)
  ) u_ptr (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_req_i (valid_i),
    .pop_req_i  (ready_i),
    .wr_addr_o  (wr_addr),
    .rd_addr_o  (rd_addr),
    .push_c     (push_c),
    .pop_c      (pop_c),
    .drop_c     (drop_c),
    .empty_c    (empty_c),
    .full_c     (full_c),
    .count_o    (count_o)
  );

  // Storage is deliberately not reset; the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (push_c) mem_q[wr_addr] <= char_i;
  end

  assign char_o  = mem_q[rd_addr];
  assign valid_o = !empty_c;

`ifdef UART_LITE_RX_OVERRUN_EN
  logic overrun_q, overrun_d;

  // Sticky drop flag; set has priority over clear.
  always_comb begin
    overrun_d = overrun_q;
    if (overrun_clr_i) overrun_d = 1'b0;
    if (drop_c)        overrun_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) overrun_q <= 1'b0;
    else       overrun_q <= overrun_d;
  end

  assign overrun_o = overrun_q;

  logic unused_c;
  assign unused_c = full_c ^ pop_c;
`else
  assign overrun_o = 1'b0;

  logic unused_c;
  assign unused_c = full_c ^ pop_c ^ drop_c ^ overrun_clr_i;
`endif

endmodule

// File: tb/tb_rx_char_fifo.sv
// tb_rx_char_fifo: directed stimulus with a scoreboard queue of expected
// characters; a negedge monitor checks every handshake against the queue.
module tb_rx_char_fifo;

  localparam int unsigned DW = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

`ifdef UART_LITE_RX_OVERRUN_EN
  localparam int OVR = 1;
`else
  localparam int OVR = 0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [DW-1:0] char_i = '0;
  logic          valid_i = 1'b0;
  logic [DW-1:0] char_o;
  logic          valid_o;
  logic          ready_i = 1'b0;
  logic [CW-1:0] count_o;
  logic          overrun_o;
  logic          overrun_clr_i = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  logic [DW-1:0] sb_q[$];

  rx_char_fifo #(.DATA_BITS(DW), .DEPTH(DEPTH)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .char_i        (char_i),
    .valid_i       (valid_i),
    .char_o        (char_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .count_o       (count_o),
    .overrun_o     (overrun_o),
    .overrun_clr_i (overrun_clr_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  // Inputs change just after a rising edge and hold through the next one.
  task automatic step(input logic v, input logic [DW-1:0] c, input logic r, input logic clr);
    valid_i = v;
    char_i = c;
    ready_i = r;
    overrun_clr_i = clr;
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_exp(input logic [DW-1:0] c, input logic r);
    sb_q.push_back(c);
    step(1'b1, c, r, 1'b0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic fill16(input logic [DW-1:0] base);
    for (int i = 0; i < 16; i++) push_exp(base + DW'(i), 1'b0);
  endtask

  // Monitor: every accepted head must match the oldest expected character.
  always @(negedge clk_i) begin
    if (!rst_i && valid_o && ready_i) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: got char_o=%0h, required no output", char_o);
      end else begin
        check("char_out", int'(char_o), int'(sb_q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk_i); #1;
    step(1'b0, '0, 1'b0, 1'b0);
    rst_i = 1'b0;
    check("rst_valid", int'(valid_o), 0);
    check("rst_count", int'(count_o), 0);
    check("rst_ovr", int'(overrun_o), 0);

    // Basic three-character sequence with consumer stalled.
    push_exp(8'h41, 1'b0);
    check("lat_valid", int'(valid_o), 1);
    check("lat_char", int'(char_o), 'h41);
    push_exp(8'h42, 1'b0);
    push_exp(8'h43, 1'b0);
    check("abc_count", int'(count_o), 3);
    check("abc_valid", int'(valid_o), 1);
    check("abc_head", int'(char_o), 'h41);
    drain(3);
    check("abc_valid_end", int'(valid_o), 0);
    check("abc_count_end", int'(count_o), 0);

    // Full FIFO drops an unpopped character.
    fill16(8'h00);
    check("full_count", int'(count_o), 16);
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    check("drop_count", int'(count_o), 16);
    check("drop_ovr", int'(overrun_o), OVR);
    drain(16);
    check("drop_valid_end", int'(valid_o), 0);
    step(1'b0, '0, 1'b0, 1'b1);
    check("ovr_clr", int'(overrun_o), 0);

    // Full FIFO accepts a push coincident with a pop.
    fill16(8'h10);
    push_exp(8'hBB, 1'b1);
    check("pp_count", int'(count_o), 16);
    check("pp_ovr", int'(overrun_o), 0);
    drain(16);
    check("pp_valid_end", int'(valid_o), 0);

    // Empty FIFO with ready held: no pop until the character lands.
    push_exp(8'h55, 1'b1);
    check("e_valid", int'(valid_o), 1);
    check("e_char", int'(char_o), 'h55);
    step(1'b0, '0, 1'b1, 1'b0);
    check("e_valid_end", int'(valid_o), 0);

    // 40 characters with interleaved pops, pointers wrap past 2*DEPTH.
    for (int i = 0; i < 40; i++) push_exp(8'h60 + DW'(i), (i % 4) != 0);
    drain(20);
    check("wrap_valid_end", int'(valid_o), 0);
    check("wrap_count_end", int'(count_o), 0);

    // Clear coincident with a drop: set wins.
    fill16(8'hC0);
    step(1'b1, 8'hCC, 1'b0, 1'b1);
    check("clr_drop_ovr", int'(overrun_o), OVR);
    check("clr_drop_count", int'(count_o), 16);
    drain(16);
    check("clr_drop_valid_end", int'(valid_o), 0);

    // Reset mid-operation discards contents.
    for (int i = 0; i < 5; i++) push_exp(8'hE0 + DW'(i), 1'b0);
    check("pre_rst_count", int'(count_o), 5);
    check("pre_rst_ovr", int'(overrun_o), OVR);
    rst_i = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0);
    rst_i = 1'b0;
    sb_q.delete();
    check("mid_rst_count", int'(count_o), 0);
    check("mid_rst_valid", int'(valid_o), 0);
    check("mid_rst_ovr", int'(overrun_o), 0);
    drain(2);
    check("post_rst_valid", int'(valid_o), 0);

    check("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
